// File: rtl/cpu_pkg.sv
// Shared types and constants for the pipeline hazard logic: the scoreboard
// entry layout, the EX operand forwarding encodings and the default sizes.
package cpu_pkg;

    localparam int CPU_NREG  = 32;
    localparam int CPU_AW    = $clog2(CPU_NREG);
    localparam int CPU_DEPTH = 3;

    // EX operand source selects
    localparam logic [1:0] FWD_RF  = 2'b00;  // register file
    localparam logic [1:0] FWD_MEM = 2'b01;  // MEM-stage ALU result
    localparam logic [1:0] FWD_WB  = 2'b10;  // WB-stage write data

    // One in-flight instruction; an all-zero entry is a bubble
    typedef struct packed {
        logic              valid;
        logic [CPU_AW-1:0] rd;
        logic              wr;
        logic              load;
        logic [CPU_AW-1:0] rs;
        logic [CPU_AW-1:0] rt;
        logic              rs_used;
        logic              rt_used;
    } sb_entry_t;

endpackage

// File: rtl/hazard_cmp.sv
// Compares one source register against one scoreboard entry. A hit means the
// entry will write the register being read; register 0 never hits.
module hazard_cmp
    import cpu_pkg::*;
(
    input  logic [CPU_AW-1:0] src,
    input  logic              src_used,
    input  sb_entry_t         entry,
    output logic              match
);

    assign match = entry.valid & entry.wr & (entry.rd == src) &
                   (src != '0) & src_used;

    // Fields not involved in the comparison
    logic unused_fields;
    assign unused_fields = ^{entry.load, entry.rs, entry.rt,
                             entry.rs_used, entry.rt_used};

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard controller for the 5-stage core. A shift-register
// scoreboard mirrors EX/MEM/WB; decode is stalled on read-after-write hazards
// and younger instructions are squashed on a taken branch.
// Build option: define HAZARD_FWD_EN to drive the EX forwarding selects and
// shrink stalls to the load-use and WB-collision cases.
//
// Issue handshake: ID offers an instruction with issue_valid=1 and it is
// accepted on a rising edge where stall=0 and flush=0. While stall=1 the ID
// stage must hold the same instruction; on flush=1 it is discarded.
module hazard_scoreboard
    import cpu_pkg::*;
#(
    parameter int NREG        = CPU_NREG,
    parameter int AW          = $clog2(NREG),
    parameter int DEPTH       = CPU_DEPTH,
    parameter int FLUSH_STAGE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rs,
    input  logic [AW-1:0]   issue_rt,
    input  logic            issue_rs_used,
    input  logic            issue_rt_used,
    input  logic [AW-1:0]   issue_rd,
    input  logic            issue_wr,
    input  logic            issue_load,
    input  logic            flush,
    output logic            stall,
    output logic [1:0]      fwd_a,
    output logic [1:0]      fwd_b,
    output logic [NREG-1:0] pending,
    output logic [31:0]     stall_cnt
);

    // index 0 = EX, 1 = MEM, DEPTH-1 = WB
    sb_entry_t [DEPTH-1:0] entries;
    sb_entry_t             issue_entry;
    logic      [DEPTH-1:0] rs_hit;
    logic      [DEPTH-1:0] rt_hit;
    logic                  raw_hazard;

    // ID source registers against every tracked stage
    for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
        hazard_cmp u_rs (
            .src      (CPU_AW'(issue_rs)),
            .src_used (issue_rs_used),
            .entry    (entries[g]),
            .match    (rs_hit[g])
        );
        hazard_cmp u_rt (
            .src      (CPU_AW'(issue_rt)),
            .src_used (issue_rt_used),
            .entry    (entries[g]),
            .match    (rt_hit[g])
        );
    end

`ifdef HAZARD_FWD_EN
    logic fa_mem, fa_wb, fb_mem, fb_wb;

    // EX sources against the MEM and WB producers
    hazard_cmp u_fa_mem (.src(entries[0].rs), .src_used(entries[0].rs_used),
                         .entry(entries[1]),       .match(fa_mem));
    hazard_cmp u_fa_wb  (.src(entries[0].rs), .src_used(entries[0].rs_used),
                         .entry(entries[DEPTH-1]), .match(fa_wb));
    hazard_cmp u_fb_mem (.src(entries[0].rt), .src_used(entries[0].rt_used),
                         .entry(entries[1]),       .match(fb_mem));
    hazard_cmp u_fb_wb  (.src(entries[0].rt), .src_used(entries[0].rt_used),
                         .entry(entries[DEPTH-1]), .match(fb_wb));

    // Only a load in EX (data not ready yet) or a WB producer (register file
    // written too late for this read) must hold decode
    assign raw_hazard = ((rs_hit[0] | rt_hit[0]) & entries[0].load) |
                        rs_hit[DEPTH-1] | rt_hit[DEPTH-1];

    // Forwarding select, the younger MEM result wins over WB
    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (fa_mem)     fwd_a = FWD_MEM;
        else if (fa_wb) fwd_a = FWD_WB;
        if (fb_mem)     fwd_b = FWD_MEM;
        else if (fb_wb) fwd_b = FWD_WB;
    end
`else
    // Without forwarding any in-flight producer holds decode
    assign raw_hazard = |{rs_hit, rt_hit};
    assign fwd_a      = FWD_RF;
    assign fwd_b      = FWD_RF;
`endif

    // A taken branch overrides the stall: the ID instruction is squashed anyway
    assign stall = issue_valid & raw_hazard & ~flush;

    // Build the EX entry: accepted ID instruction or a bubble
    always_comb begin
        issue_entry = '0;
        if (issue_valid & ~stall & ~flush) begin
            issue_entry.valid   = 1'b1;
            issue_entry.rd      = CPU_AW'(issue_rd);
            issue_entry.wr      = issue_wr;
            issue_entry.load    = issue_load;
            issue_entry.rs      = CPU_AW'(issue_rs);
            issue_entry.rt      = CPU_AW'(issue_rt);
            issue_entry.rs_used = issue_rs_used;
            issue_entry.rt_used = issue_rt_used;
        end
    end

    // Advance the scoreboard; a flush turns the younger shifted entries into bubbles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entries <= '0;
        end else begin
            entries[0] <= issue_entry;
            for (int i = 1; i < DEPTH; i++) begin
                entries[i] <= (flush && (i <= FLUSH_STAGE)) ? sb_entry_t'('0)
                                                            : entries[i-1];
            end
        end
    end

    // Registers that some in-flight instruction will still write
    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entries[i].valid && entries[i].wr && (entries[i].rd != '0))
                pending[entries[i].rd] = 1'b1;
        end
    end

    // Saturating count of stalled cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (stall && (stall_cnt != 32'hFFFF_FFFF))
            stall_cnt <= stall_cnt + 32'd1;
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios followed by random issue
// traffic, all checked against a model that tracks in-flight instructions
// by age. Works with or without HAZARD_FWD_EN.
module tb_hazard_scoreboard;

  localparam int NREG        = 32;
  localparam int AW          = 5;
  localparam int DEPTH       = 3;
  localparam int FLUSH_STAGE = 1;

  logic            clk;
  logic            rst_n;
  logic            issue_valid;
  logic [AW-1:0]   issue_rs;
  logic [AW-1:0]   issue_rt;
  logic            issue_rs_used;
  logic            issue_rt_used;
  logic [AW-1:0]   issue_rd;
  logic            issue_wr;
  logic            issue_load;
  logic            flush;
  logic            stall;
  logic [1:0]      fwd_a;
  logic [1:0]      fwd_b;
  logic [NREG-1:0] pending;
  logic [31:0]     stall_cnt;

  hazard_scoreboard #(
    .NREG(NREG), .AW(AW), .DEPTH(DEPTH), .FLUSH_STAGE(FLUSH_STAGE)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_rs(issue_rs), .issue_rt(issue_rt),
    .issue_rs_used(issue_rs_used), .issue_rt_used(issue_rt_used),
    .issue_rd(issue_rd), .issue_wr(issue_wr), .issue_load(issue_load),
    .flush(flush), .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .pending(pending), .stall_cnt(stall_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  typedef struct {
    int stage;  // cycles since it left ID: 0 = EX, 1 = MEM, 2 = WB
    int rd;
    bit wr;
    bit ld;
    int rs;
    int rt;
    bit rsu;
    bit rtu;
  } instr_t;

  instr_t      inflight[$];
  logic [31:0] exp_q[$];
  int          model_cnt;
  bit          last_stall;
  int          n_vec;
  int          n_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Does instruction w produce the register read as src?
  function automatic bit reads(input int src, input bit used, input instr_t w);
    return used && (src != 0) && w.wr && (w.rd == src);
  endfunction

`ifdef HAZARD_FWD_EN
  function automatic logic [1:0] fwd_pick(input int src, input bit used);
    logic [1:0] r;
    r = 2'b00;
    foreach (inflight[k])
      if (inflight[k].stage == DEPTH-1 && reads(src, used, inflight[k])) r = 2'b10;
    foreach (inflight[k])
      if (inflight[k].stage == 1 && reads(src, used, inflight[k])) r = 2'b01;
    return r;
  endfunction
`endif

  // ---------------- driver ----------------
  // One cycle: drive ID/flush, check outputs against the model, then age the model.
  task automatic step(input bit v, input int rs, input int rt, input bit rsu, input bit rtu,
                      input int rd, input bit wr, input bit ld, input bit fl);
    bit          st;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [31:0] pend;
    instr_t      x;
    instr_t      nq[$];
    @(negedge clk);
    issue_valid   = v;
    issue_rs      = AW'(rs);
    issue_rt      = AW'(rt);
    issue_rs_used = rsu;
    issue_rt_used = rtu;
    issue_rd      = AW'(rd);
    issue_wr      = wr;
    issue_load    = ld;
    flush         = fl;
    #1;
    pend = '0;
    st   = 1'b0;
    fa   = 2'b00;
    fb   = 2'b00;
    foreach (inflight[k]) begin
      if (inflight[k].wr && inflight[k].rd != 0) pend[inflight[k].rd] = 1'b1;
      if (reads(rs, rsu, inflight[k]) || reads(rt, rtu, inflight[k])) begin
`ifdef HAZARD_FWD_EN
        if ((inflight[k].stage == 0 && inflight[k].ld) || inflight[k].stage == DEPTH-1)
          st = 1'b1;
`else
        st = 1'b1;
`endif
      end
`ifdef HAZARD_FWD_EN
      if (inflight[k].stage == 0) begin
        fa = fwd_pick(inflight[k].rs, inflight[k].rsu);
        fb = fwd_pick(inflight[k].rt, inflight[k].rtu);
      end
`endif
    end
    st = st && v && !fl;
    exp_q.push_back({31'b0, st});
    exp_q.push_back({30'b0, fa});
    exp_q.push_back({30'b0, fb});
    exp_q.push_back(pend);
    exp_q.push_back(model_cnt);
    check("stall",     {31'b0, stall}, exp_q.pop_front());
    check("fwd_a",     {30'b0, fwd_a}, exp_q.pop_front());
    check("fwd_b",     {30'b0, fwd_b}, exp_q.pop_front());
    check("pending",   pending,        exp_q.pop_front());
    check("stall_cnt", stall_cnt,      exp_q.pop_front());
    // age everything by one stage; flush kills what leaves EX
    foreach (inflight[k]) begin
      x = inflight[k];
      if (fl && x.stage < FLUSH_STAGE) continue;
      x.stage++;
      if (x.stage < DEPTH) nq.push_back(x);
    end
    if (v && !st && !fl) begin
      x.stage = 0; x.rd = rd; x.wr = wr; x.ld = ld;
      x.rs = rs; x.rt = rt; x.rsu = rsu; x.rtu = rtu;
      nq.push_back(x);
    end
    inflight = nq;
    if (st) model_cnt++;
    last_stall = st;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Hold one instruction in ID until accepted; returns the number of stalled cycles.
  task automatic issue_until(input int rs, input int rt, input bit rsu, input bit rtu,
                             input int rd, input bit wr, input bit ld, output int stalls);
    int tries;
    stalls = 0;
    tries  = 0;
    do begin
      step(1, rs, rt, rsu, rtu, rd, wr, ld, 0);
      if (last_stall) stalls++;
      tries++;
    end while (last_stall && tries < 10);
    check("issue_accepted", {31'b0, last_stall}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n       = 1'b0;
    issue_valid = 1'b1;
    issue_rs    = 5'd10;
    issue_rs_used = 1'b1;
    flush       = 1'b0;
    #1;
    check("rst_stall",     {31'b0, stall}, 32'd0);
    check("rst_pending",   pending,        32'd0);
    check("rst_stall_cnt", stall_cnt,      32'd0);
    check("rst_fwd",       {28'b0, fwd_a, fwd_b}, 32'd0);
    inflight.delete();
    model_cnt = 0;
    @(negedge clk);
    issue_valid = 1'b0;
    rst_n       = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int stalls;
    n_vec = 0; n_err = 0; model_cnt = 0; last_stall = 1'b0;
    rst_n = 1'b0; issue_valid = 1'b0; issue_rs = '0; issue_rt = '0;
    issue_rs_used = 1'b0; issue_rt_used = 1'b0; issue_rd = '0;
    issue_wr = 1'b0; issue_load = 1'b0; flush = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("init_pending",   pending,        32'd0);
    check("init_stall_cnt", stall_cnt,      32'd0);
    check("init_stall",     {31'b0, stall}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // add $3 ; sub reads $3 on the next cycle
    step(1, 1, 2, 1, 1, 3, 1, 0, 0);
    issue_until(3, 4, 1, 1, 9, 1, 0, stalls);
    idle(1);
`ifdef HAZARD_FWD_EN
    check("addsub_stalls", stalls, 32'd0);
    check("addsub_fwd_a",  {30'b0, fwd_a}, 32'd1);
    check("addsub_cnt",    stall_cnt, 32'd0);
`else
    check("addsub_stalls", stalls, 32'd3);
    check("addsub_cnt",    stall_cnt, 32'd3);
`endif
    idle(3);

    // lw $5 ; add reads $5
    step(1, 1, 0, 1, 0, 5, 1, 1, 0);
    issue_until(5, 0, 1, 0, 6, 1, 0, stalls);
    idle(1);
`ifdef HAZARD_FWD_EN
    check("loaduse_stalls", stalls, 32'd1);
    check("loaduse_fwd_a",  {30'b0, fwd_a}, 32'd2);
`else
    check("loaduse_stalls", stalls, 32'd3);
`endif
    idle(3);

    // writer of $0 then reader of $0
    step(1, 1, 1, 1, 1, 0, 1, 0, 0);
    step(1, 0, 0, 1, 1, 8, 0, 0, 0);
    check("zero_stall",   {31'b0, stall}, 32'd0);
    check("zero_pending", pending,        32'd0);
    check("zero_fwd",     {28'b0, fwd_a, fwd_b}, 32'd0);
    idle(3);

    // writer of $7 in EX, reader of $7 in ID, branch resolves in MEM
    step(1, 1, 2, 1, 1, 7, 1, 0, 0);
    step(1, 7, 7, 1, 1, 8, 1, 0, 1);
    check("flush_stall", {31'b0, stall}, 32'd0);
    idle(1);
    check("flush_pend7", {31'b0, pending[7]}, 32'd0);
    check("flush_fwd",   {28'b0, fwd_a, fwd_b}, 32'd0);
    idle(3);

    // three writers in flight, then reset
    step(1, 0, 0, 0, 0, 10, 1, 0, 0);
    step(1, 0, 0, 0, 0, 11, 1, 0, 0);
    step(1, 0, 0, 0, 0, 12, 1, 1, 0);
    do_reset();
    step(1, 10, 11, 1, 1, 13, 1, 0, 0);
    check("post_rst_stall", {31'b0, stall}, 32'd0);

    // random traffic over a small register window so hazards are frequent
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 3) != 0,
           $urandom_range(0, 7), $urandom_range(0, 7),
           $urandom_range(0, 1), $urandom_range(0, 1),
           $urandom_range(0, 7), $urandom_range(0, 3) != 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
      if (n == 300) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised pipeline hazard controller for the 5-stage MIPS core. Sits beside the ID/EX/MEM/WB stage registers. Tracks every in-flight register-writing instruction in a shift-register scoreboard and stalls decode on read-after-write hazards. Squashes younger instructions on a taken branch, and optionally drives EX-stage operand forwarding selects. Replaces the current hazard-free pipeline's assumption that software inserts NOPs.

## Interface
- NREG, 32: architectural register count; register 0 is hard-wired zero and never hazards.
- AW, $clog2(NREG): register address width.
- DEPTH, 3: tracked stages after ID; index 0 = EX, 1 = MEM, 2 = WB.
- FLUSH_STAGE, 1: index of the stage that resolves branches (MEM).
- CLOCK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- issue_valid  in  1  ID holds a real instruction.
- issue_rs, issue_rt  in  AW each  ID source registers.
- issue_rs_used, issue_rt_used  in  1 each  source actually read.
- issue_rd  in  AW  destination register.
- issue_wr  in  1  instruction writes a register.
- issue_load  in  1  result available only after MEM.
- flush  in  1  taken branch resolved in stage FLUSH_STAGE this cycle.
- stall  out  1  hold PC and IF/ID; inject bubble into EX.
- fwd_a, fwd_b  out  2 each  EX operand source (FWD_EN only, else tied 00).
- pending  out  NREG  bit r set while any valid entry will write r.
- stall_cnt  out  32  cycles with stall=1 since reset, saturating.

## Operation
- Entry fields: valid, rd, wr, load, rs, rt, rs_used, rt_used.
- Each rising edge, entry[i+1] <= entry[i] for i < DEPTH-1; entry[DEPTH-1] retires.
- entry[0] gets the ID instruction if issue_valid & !stall & !flush, else a bubble (valid=0).
- On flush: the entries that shift into indices 1..FLUSH_STAGE (the old EX contents) become bubbles, as does the incoming ID instruction. The older stages shift normally.
- Match(src, e): e.valid & e.wr & e.rd == src & src != 0 & src_used.
- Without FWD_EN: stall = issue_valid & any Match over all DEPTH entries, for rs or rt.
- With FWD_EN, stall = issue_valid & (Match vs entry[0] with entry[0].load, or Match vs entry[DEPTH-1]).
- The WB case stalls because the register file writes at the end of WB, so an ID read in that cycle sees the stale value.
- fwd encodings, evaluated on entry[0] sources:
  - 00: register file.
  - 01: MEM ALU result, when entry[1] matches.
  - 10: WB write data, when entry[2] matches.
  - MEM has priority over WB.
- stall is forced to 0 when flush=1, so flush wins over stall.
- pending is the OR of decoded rd over entries with valid & wr & rd != 0.
- stall_cnt increments when stall=1 and holds at 32'hFFFF_FFFF.

## Timing
- stall, fwd_a, fwd_b and pending are combinational from the issue inputs, flush and entry state. There is no added latency.
- A dependent instruction with no forwarding stalls up to DEPTH cycles.
- With FWD_EN, a load-use stalls 1 cycle, a WB-collision stalls 1 cycle, and every other dependency stalls 0 cycles.
- Reset (RESET=0, asynchronous):
  - All entries are invalid, pending=0, stall_cnt=0, fwd=00.
  - stall=0 while RESET is low.
- Reset mid-operation discards all in-flight state immediately; there is no drain.
- Simultaneous flush with a hazard: no stall, and the ID instruction is squashed.

## Configuration
- HAZARD_FWD_EN defined: forwarding selects are active and stall is reduced to the load-use and WB cases.
- HAZARD_FWD_EN undefined: fwd_a and fwd_b are constant 00, stall covers all DEPTH stages, and the datapath needs no forwarding muxes.

## Structure
- cpu_pkg holds:
  - the scoreboard entry struct typedef;
  - the FWD_RF, FWD_MEM and FWD_WB encodings;
  - the default NREG and DEPTH constants.
- One sub-module, hazard_cmp: compares one source register against one entry and returns the match bit.

## Test plan
- Issue add $3 (wr), then sub reading $3 on the next cycle, no FWD_EN → stall=1 for 3 cycles, then 0; stall_cnt=3.
- Same sequence with HAZARD_FWD_EN → stall=0; fwd_a=01 on the cycle sub is in EX.
- lw $5 followed by add reading $5, FWD_EN → stall=1 for exactly 1 cycle, then fwd_a=10 with add in EX.
- Writer of $0 followed by a reader of $0 → stall=0, fwd=00, pending=0.
- Branch in MEM with flush=1 while a writer of $7 is in EX and a reader of $7 is in ID:
  - stall=0 that cycle;
  - next cycle, pending[7]=0 and entry[0] is invalid.
- Assert RESET low while 3 writers are in flight → pending=0, stall_cnt=0 immediately; after release, the first issue proceeds with stall=0.
